// File: rtl/count_stim.sv
// count_stim: prescaled enable tick and synchronized push-button load pulse for a loadable counter.
// Define COUNT_STIM_DEBOUNCE_EN to insert a DEB_CYCLES stability filter ahead of the edge detector.
module count_stim #(
    parameter int DIV        = 50000000,
    parameter int DIV_W      = 26,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             load_btn,
    output logic             en,
    output logic             l,
    output logic [DIV_W-1:0] phase
);
    logic r_s1, r_s2, r_prev;
    logic w_lvl, w_rise, w_wrap;

    if (DIV < 2 || DIV_W < 1 || (DIV_W < 31 && DIV > (1 << DIV_W)) || DEB_CYCLES < 1) begin : g_bad_param
        $error("count_stim: illegal parameters");
    end

    // Flops reset high so a button held through reset never looks like a fresh press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= load_btn;
            r_s2   <= r_s1;
            r_prev <= w_lvl;
        end
    end

`ifdef COUNT_STIM_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    logic             r_f;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_f   <= 1'b1;
            r_cnt <= '0;
        end else if (r_s2 == r_f) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            r_f   <= r_s2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_lvl = r_f;
`else
    assign w_lvl = r_s2;
`endif

    assign w_rise = w_lvl & ~r_prev;
    assign w_wrap = run && (phase == DIV_W'(DIV - 1));

    // A load restarts the period and suppresses any tick in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase <= '0;
            en    <= 1'b0;
            l     <= 1'b0;
        end else begin
            l     <= w_rise;
            en    <= ~w_rise & w_wrap;
            phase <= (w_rise || w_wrap) ? '0 : run ? phase + 1'b1 : phase;
        end
    end
endmodule

// File: tb/tb_count_stim.sv
// tb_count_stim: directed checks of count_stim with DIV=4, DIV_W=2, DEB_CYCLES=5.
module tb_count_stim;
    localparam int DIV = 4;
    localparam int DEB = 5;
`ifdef COUNT_STIM_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       resetn, run, load_btn;
    logic       en, l;
    logic [1:0] phase;
    int         checks = 0;
    int         errors = 0;

    count_stim #(.DIV(DIV), .DIV_W(2), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .resetn(resetn), .run(run), .load_btn(load_btn),
        .en(en), .l(l), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; run = 1'b0; load_btn = 1'b0;
        #2;
        chk("rst_en", en, 0);
        chk("rst_l", l, 0);
        chk("rst_phase", phase, 0);
        step(); step();
        chk("rst_hold_phase", phase, 0);
        resetn = 1'b1; run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("run_phase", phase, c % 4);
            chk("run_en", en, (c % 4) == 0);
            chk("run_l", l, 0);
        end
`ifndef COUNT_STIM_DEBOUNCE_EN
        step(); step();
        chk("pre_press_phase", phase, 2);
        load_btn = 1'b1;
        step();
        chk("press1_phase", phase, 3);
        chk("press1_l", l, 0);
        step();
        chk("press2_phase", phase, 0);
        chk("press2_en", en, 1);
        chk("press2_l", l, 0);
        step();
        chk("load_l", l, 1);
        chk("load_en", en, 0);
        chk("load_phase", phase, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("post_load_phase", phase, i % 4);
            chk("post_load_en", en, i == 4);
            chk("post_load_l", l, 0);
        end
        load_btn = 1'b0;
        step(); step();
        chk("run_drop_phase_a", phase, 2);
        run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("hold_phase", phase, 2);
            chk("hold_en", en, 0);
            chk("hold_l", l, 0);
        end
        run = 1'b1;
        step();
        chk("resume1_phase", phase, 3);
        chk("resume1_en", en, 0);
        step();
        chk("resume2_phase", phase, 0);
        chk("resume2_en", en, 1);
`endif
        step(); step(); step();
        chk("pre_async_phase", phase, 3);
        resetn = 1'b0;
        #1;
        chk("async_phase", phase, 0);
        chk("async_en", en, 0);
        chk("async_l", l, 0);
        load_btn = 1'b1;
        step(); step();
        resetn = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("held_l", l, 0);
            chk("held_phase", phase, c % 4);
            chk("held_en", en, (c % 4) == 0);
        end
        load_btn = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            chk("release_l", l, 0);
        end
        load_btn = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            step();
            chk("repress_l", l, i == LAT);
            if (i == LAT) chk("repress_phase", phase, 0);
            if (i == LAT) chk("repress_en", en, 0);
        end
        load_btn = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            chk("release2_l", l, 0);
        end
`ifdef COUNT_STIM_DEBOUNCE_EN
        load_btn = 1'b1;
        step(); step(); step();
        load_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("glitch_l", l, 0);
        end
        load_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("deb_press_l", l, i == 8);
        end
        load_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("deb_release_l", l, 0);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
